tmds_link_sequencer: RTL and testbench
======================================

Name: tmds_link_sequencer

Overview:
Bring-up and supervision controller for the three-channel TMDS serializer path. It filters the pixel/serial MMCM lock and holds the OSERDES pair in reset for a defined interval. It then drives a guard band of blanking control symbols and switches to live encoder data only on a frame boundary. It sits between the three TMDS encoders and the three serializers, in the pixel_clk domain.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before serializer reset release begins
RST_HOLD_CYCLES, 16, pixel_clk cycles serdes_rst stays high after lock is qualified
GUARD_CYCLES, 64, pixel_clk cycles of blanking symbols after serdes_rst deasserts
CNT_W, 16, shared phase-counter width; must hold max(parameters) (static check at elaboration)
RELOCK_W, 8, width of saturating relock counter

Ports:
pixel_clk  in  1  sole clock
rst_n  in  1  synchronous, active-low reset
mmcm_locked  in  1  asynchronous MMCM lock, synchronised internally
frame_start  in  1  single-cycle pulse aligned with first encoder word of a frame
enc_tmds_ch0  in  10  encoder word, channel 0 (blue/sync)
enc_tmds_ch1  in  10  encoder word, channel 1
enc_tmds_ch2  in  10  encoder word, channel 2
tmds_ch0  out  10  word to serializer, channel 0 (registered)
tmds_ch1  out  10  word to serializer, channel 1 (registered)
tmds_ch2  out  10  word to serializer, channel 2 (registered)
serdes_rst  out  1  active-high reset to all OSERDES instances (registered)
link_up  out  1  high only in LIVE (registered)
seq_state  out  3  current state encoding, for debug
relock_count  out  RELOCK_W  number of lock losses since reset, saturating

Behaviour:
- Reset (rst_n=0 at an edge): state WAIT_LOCK, counter 0, sync flops 0, serdes_rst=1, tmds_ch*=BLANK (10'b1101010100, C1C0=00), link_up=0, relock_count=0.
- lock_s = mmcm_locked through a 2-flop synchroniser. Its latency is 2 cycles.
- States: WAIT_LOCK=0, SERDES_RST=1, GUARD=2, WAIT_FRAME=3, LIVE=4. The counter clears on every state entry.
- WAIT_LOCK: serdes_rst=1. Counter increments while lock_s=1 and clears to 0 on lock_s=0. When the counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1, go to SERDES_RST.
- SERDES_RST: serdes_rst=1 for exactly RST_HOLD_CYCLES cycles, then go to GUARD.
- GUARD: serdes_rst=0, outputs BLANK for exactly GUARD_CYCLES cycles, then go to WAIT_FRAME.
- WAIT_FRAME: outputs BLANK. On frame_start=1, go to LIVE. frame_start in any other state is ignored.
- LIVE: link_up=1. The state persists until lock loss.
- Output mux: at each edge, tmds_chN <= (next_state==LIVE) ? enc_tmds_chN : BLANK. The word present with the accepted frame_start is the first live word out, 1-cycle latency.
- serdes_rst and link_up are registered from next_state, so they change on the same edge as the state.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK goes to WAIT_LOCK next edge. On that edge serdes_rst=1, outputs BLANK, link_up=0, and relock_count increments, saturating at all-ones.
- Lock loss takes priority over frame_start and over counter expiry in the same cycle.
- rst_n low mid-operation (including LIVE) gives the reset values on that edge, with no drain of in-flight words.

Decomposition:
- Shared package hdmi_pkg: TMDS control-symbol constants (C00=10'b1101010100, C01=10'b0010101011, C10=10'b0101010100, C11=10'b1010101011), seq_state enum, TMDS_W=10.
- One sub-module: sync_2ff (single-bit synchroniser with sync active-low reset, output 0). It is reused elsewhere for CDC of lock/hotplug.

Test Plan:
- Params LOCK=8, RST=4, GUARD=6, with mmcm_locked high from cycle 0 -> serdes_rst falls 2+8+4 edges after reset release. BLANK continues through GUARD and WAIT_FRAME. A frame_start with enc_ch0=10'h2AA makes tmds_ch0=10'h2AA and link_up=1 on the next edge.
- mmcm_locked low for 1 cycle at lock-count 5 during WAIT_LOCK -> counter restarts, SERDES_RST entry delayed by 8+ cycles, relock_count stays 0.
- frame_start pulsed during GUARD -> ignored. The sequencer remains in WAIT_FRAME with BLANK output until the next pulse.
- Lock drop while LIVE -> after 2-cycle sync, serdes_rst=1, tmds_ch*=10'b1101010100, link_up=0, relock_count=1, state=0. Full bring-up repeats on relock.
- Lock drop in the same cycle as frame_start in WAIT_FRAME -> WAIT_LOCK wins and LIVE is never entered. After 256 loss events, relock_count holds 8'hFF.
- rst_n low for one cycle mid-LIVE -> all outputs at reset values on that edge, relock_count=0.

Source files
------------

// File: rtl/tmds_link_sequencer_pkg.sv
// Shared HDMI/TMDS definitions: control symbols, word width and the
// link-sequencer state encoding.
package hdmi_pkg;

  localparam int unsigned TMDS_W = 10;

  // TMDS control symbols indexed by {C1,C0}
  localparam logic [TMDS_W-1:0] C00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] C01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] C10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] C11 = 10'b1010101011;

  // Blanking word driven on every channel outside LIVE
  localparam logic [TMDS_W-1:0] BLANK = C00;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_SERDES_RST = 3'd1,
    ST_GUARD      = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_LIVE       = 3'd4
  } seq_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tmds_link_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-low reset to 0.
// Shared by the lock and hotplug CDC paths.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmds_link_sequencer.sv
// TMDS link bring-up sequencer: lock qualification, OSERDES reset hold,
// blanking guard band and frame-aligned switch to live encoder data.
module tmds_link_sequencer
  import hdmi_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned GUARD_CYCLES       = 64,
  parameter int unsigned CNT_W              = 16,
  parameter int unsigned RELOCK_W           = 8
) (
  input  logic                pixel_clk,
  input  logic                rst_n,
  input  logic                mmcm_locked,
  input  logic                frame_start,
  input  logic [TMDS_W-1:0]   enc_tmds_ch0,
  input  logic [TMDS_W-1:0]   enc_tmds_ch1,
  input  logic [TMDS_W-1:0]   enc_tmds_ch2,
  output logic [TMDS_W-1:0]   tmds_ch0,
  output logic [TMDS_W-1:0]   tmds_ch1,
  output logic [TMDS_W-1:0]   tmds_ch2,
  output logic                serdes_rst,
  output logic                link_up,
  output logic [2:0]          seq_state,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int unsigned MAX_PHASE =
    max3(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, GUARD_CYCLES);

  if (CNT_W < 1 || CNT_W > 32 || longint'(MAX_PHASE) > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_check
    $error("tmds_link_sequencer: CNT_W too narrow for the phase lengths");
  end
  if (LOCK_STABLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || GUARD_CYCLES < 1) begin : g_len_check
    $error("tmds_link_sequencer: phase lengths must be at least 1");
  end
  if (RELOCK_W < 1) begin : g_relock_w_check
    $error("tmds_link_sequencer: RELOCK_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_s;
  logic             lock_lost;

  sync_2ff u_lock_sync (
    .clk   (pixel_clk),
    .rst_n (rst_n),
    .d     (mmcm_locked),
    .q     (lock_s)
  );

  // Lock loss overrides both frame_start and phase-counter expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_lost = (state_q != ST_WAIT_LOCK) && !lock_s;
    if (lock_lost) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_SERDES_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SERDES_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_WAIT_FRAME;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_FRAME: begin
          cnt_d = '0;
          if (frame_start) state_d = ST_LIVE;
        end
        ST_LIVE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from state_d so they move on the same edge as the state.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      serdes_rst   <= 1'b1;
      link_up      <= 1'b0;
      tmds_ch0     <= BLANK;
      tmds_ch1     <= BLANK;
      tmds_ch2     <= BLANK;
      relock_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      serdes_rst <= (state_d == ST_WAIT_LOCK) || (state_d == ST_SERDES_RST);
      link_up    <= (state_d == ST_LIVE);
      tmds_ch0   <= (state_d == ST_LIVE) ? enc_tmds_ch0 : BLANK;
      tmds_ch1   <= (state_d == ST_LIVE) ? enc_tmds_ch1 : BLANK;
      tmds_ch2   <= (state_d == ST_LIVE) ? enc_tmds_ch2 : BLANK;
      if (lock_lost && (relock_count != '1)) begin
        relock_count <= relock_count + RELOCK_W'(1);
      end
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Self-checking bench for tmds_link_sequencer against a cycle-level
// behavioural model of the bring-up rules.
module tb_tmds_link_sequencer;

  localparam int unsigned LOCK  = 8;
  localparam int unsigned RSTH  = 4;
  localparam int unsigned GRD   = 6;
  localparam logic [9:0]  BLANK_W = 10'b1101010100;

  logic       pixel_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] enc0 = '0, enc1 = '0, enc2 = '0;
  logic [9:0] t0, t1, t2;
  logic       serdes_rst, link_up;
  logic [2:0] seq_state;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;
  int mism = 0;
  string mism_msg = "";

  always #5 pixel_clk = ~pixel_clk;

  tmds_link_sequencer #(
    .LOCK_STABLE_CYCLES (LOCK),
    .RST_HOLD_CYCLES    (RSTH),
    .GUARD_CYCLES       (GRD),
    .CNT_W              (16),
    .RELOCK_W           (8)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .mmcm_locked  (mmcm_locked),
    .frame_start  (frame_start),
    .enc_tmds_ch0 (enc0),
    .enc_tmds_ch1 (enc1),
    .enc_tmds_ch2 (enc2),
    .tmds_ch0     (t0),
    .tmds_ch1     (t1),
    .tmds_ch2     (t2),
    .serdes_rst   (serdes_rst),
    .link_up      (link_up),
    .seq_state    (seq_state),
    .relock_count (relock_count)
  );

  // Reference model: phase 0..4 = wait-lock, serdes-reset, guard, wait-frame, live.
  // Lock qualification counts a run of high synchronised samples; timed phases count down.
  bit         d1 = 0, d2 = 0;
  int         m_phase = 0, m_run = 0, m_left = 0;
  logic       m_rst = 1'b1, m_up = 1'b0;
  logic [7:0] m_rel = '0;
  logic [9:0] m0 = BLANK_W, m1 = BLANK_W, m2 = BLANK_W;

  always @(posedge pixel_clk) begin : ref_model
    bit ls;
    if (!rst_n) begin
      d1 = 0; d2 = 0; m_phase = 0; m_run = 0; m_left = 0; m_rel = '0;
    end else begin
      ls = d2; d2 = d1; d1 = mmcm_locked;
      if (m_phase != 0 && !ls) begin
        m_phase = 0; m_run = 0;
        if (m_rel != 8'hFF) m_rel = m_rel + 8'd1;
      end else begin
        case (m_phase)
          0: begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == LOCK) begin m_phase = 1; m_left = RSTH; end
          end
          1: begin
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_left = GRD; end
          end
          2: begin
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
          3: if (frame_start) m_phase = 4;
          default: ;
        endcase
      end
    end
    m_rst = (m_phase <= 1);
    m_up  = (m_phase == 4);
    m0 = (m_phase == 4) ? enc0 : BLANK_W;
    m1 = (m_phase == 4) ? enc1 : BLANK_W;
    m2 = (m_phase == 4) ? enc2 : BLANK_W;
  end

  // One clock: sample after the edge, log any divergence from the model, then new random words.
  task automatic tick();
    logic [42:0] o, e;
    @(posedge pixel_clk); #1;
    o = {serdes_rst, link_up, seq_state, relock_count, t0, t1, t2};
    e = {m_rst, m_up, 3'(m_phase), m_rel, m0, m1, m2};
    if (o !== e) begin
      if (mism == 0) mism_msg = $sformatf("t=%0t dut=%h model=%h", $time, o, e);
      mism++;
    end
    enc0 = 10'($urandom); enc1 = 10'($urandom); enc2 = 10'($urandom);
  endtask

  task automatic do_reset(input logic lock);
    rst_n = 1'b0; frame_start = 1'b0;
    tick(); tick();
    rst_n = 1'b1; mmcm_locked = lock;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    int n = 0;
    while (seq_state !== st && n < budget) begin tick(); n++; end
    ok = (seq_state === st);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mmcm_locked = 1'($urandom); frame_start = 1'($urandom);
    tick();
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", seq_state); end
    checks++; if (serdes_rst !== 1'b1) begin errors++; $display("FAIL reset_serdes_rst got %b want 1", serdes_rst); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up got %b want 0", link_up); end
    checks++; if ({t0, t1, t2} !== {3{BLANK_W}}) begin errors++; $display("FAIL reset_tmds got %h %h %h want %h", t0, t1, t2, BLANK_W); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL reset_relock got %0d want 0", relock_count); end
    frame_start = 1'b0;
    mism = 0;
  endtask

  task automatic test_bringup();
    int n = 0;
    bit ok;
    do_reset(1'b1);
    while (serdes_rst !== 1'b0 && n < 100) begin tick(); n++; end
    checks++; if (n != 2 + LOCK + RSTH) begin errors++; $display("FAIL bringup_rst_fall got edge %0d want %0d", n, 2 + LOCK + RSTH); end
    wait_state(3'd3, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bringup_wait_frame got state %0d want 3", seq_state); end
    tick();
    checks++; if (t0 !== BLANK_W || link_up !== 1'b0) begin errors++; $display("FAIL bringup_blank got %h/%b want %h/0", t0, link_up, BLANK_W); end
    frame_start = 1'b1; enc0 = 10'h2AA;
    tick();
    frame_start = 1'b0;
    checks++; if (t0 !== 10'h2AA) begin errors++; $display("FAIL bringup_first_word got %h want 2aa", t0); end
    checks++; if (link_up !== 1'b1 || seq_state !== 3'd4) begin errors++; $display("FAIL bringup_live got %b/%0d want 1/4", link_up, seq_state); end
    repeat (20) tick();
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_bringup %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  task automatic test_lock_glitch();
    int n = 0;
    do_reset(1'b1);
    repeat (7) begin tick(); n++; end
    mmcm_locked = 1'b0;
    tick(); n++;
    mmcm_locked = 1'b1;
    while (serdes_rst !== 1'b0 && n < 100) begin tick(); n++; end
    checks++; if (n != 22) begin errors++; $display("FAIL glitch_rst_fall got edge %0d want 22", n); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL glitch_relock got %0d want 0", relock_count); end
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_glitch %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  task automatic test_guard_frame();
    bit ok;
    do_reset(1'b1);
    wait_state(3'd2, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL guard_reach got state %0d want 2", seq_state); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL guard_ignore got state %0d want 2", seq_state); end
    wait_state(3'd3, 50, ok);
    repeat (5) tick();
    checks++; if (seq_state !== 3'd3 || t1 !== BLANK_W || link_up !== 1'b0) begin
      errors++; $display("FAIL guard_hold got %0d/%h/%b want 3/%h/0", seq_state, t1, link_up, BLANK_W);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL guard_then_live got state %0d want 4", seq_state); end
    repeat (5) tick();
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_guard %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  task automatic test_live_drop();
    int n = 0;
    bit ok;
    mmcm_locked = 1'b0;
    while (seq_state !== 3'd0 && n < 10) begin tick(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL drop_latency got %0d edges want 3", n); end
    checks++; if (serdes_rst !== 1'b1 || link_up !== 1'b0) begin errors++; $display("FAIL drop_ctrl got %b/%b want 1/0", serdes_rst, link_up); end
    checks++; if ({t0, t1, t2} !== {3{BLANK_W}}) begin errors++; $display("FAIL drop_tmds got %h %h %h want %h", t0, t1, t2, BLANK_W); end
    checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL drop_relock got %0d want 1", relock_count); end
    mmcm_locked = 1'b1;
    wait_state(3'd3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL relock_bringup got state %0d want 3", seq_state); end
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_live_drop %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  task automatic test_drop_with_frame();
    bit ok;
    int timeouts = 0;
    do_reset(1'b1);
    wait_state(3'd3, 100, ok);
    mmcm_locked = 1'b0;
    tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (seq_state !== 3'd0 || link_up !== 1'b0) begin errors++; $display("FAIL drop_vs_frame got %0d/%b want 0/0", seq_state, link_up); end
    checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL drop_vs_frame_relock got %0d want 1", relock_count); end
    for (int i = 0; i < 256; i++) begin
      mmcm_locked = 1'b1;
      wait_state(3'd1, 50, ok);
      if (!ok) timeouts++;
      mmcm_locked = 1'b0;
      wait_state(3'd0, 10, ok);
      if (!ok) timeouts++;
    end
    checks++; if (timeouts != 0) begin errors++; $display("FAIL relock_loop_timeouts got %0d want 0", timeouts); end
    checks++; if (relock_count !== 8'hFF) begin errors++; $display("FAIL relock_saturate got %h want ff", relock_count); end
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_drop_frame %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  task automatic test_reset_mid_live();
    bit ok;
    mmcm_locked = 1'b1;
    wait_state(3'd3, 100, ok);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL midlive_up got %b want 1", link_up); end
    rst_n = 1'b0;
    tick();
    checks++; if (seq_state !== 3'd0 || serdes_rst !== 1'b1 || link_up !== 1'b0) begin
      errors++; $display("FAIL midlive_reset_ctrl got %0d/%b/%b want 0/1/0", seq_state, serdes_rst, link_up);
    end
    checks++; if ({t0, t1, t2} !== {3{BLANK_W}}) begin errors++; $display("FAIL midlive_reset_tmds got %h %h %h want %h", t0, t1, t2, BLANK_W); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL midlive_reset_relock got %0d want 0", relock_count); end
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (mism != 0) begin errors++; $display("FAIL trace_midlive %0d cycles off model, first %s", mism, mism_msg); end
    mism = 0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_guard_frame();
    test_live_drop();
    test_drop_with_frame();
    test_reset_mid_live();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
